ultrasonico_ctrl: RTL and testbench



---
 rtl/ultrasonico_pkg.sv | 29 ++
 rtl/ultrasonico_sync.sv | 43 ++++
 rtl/ultrasonico_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_ultrasonico_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ultrasonico_pkg.sv
// -----------------------------------------------------------------------------
// ultrasonico_pkg
// Shared definitions for the ultrasonic ranging sequencer: FSM state encoding,
// default timing constants for a 50 MHz clock and a small helper used to size
// the cycle timers.
// -----------------------------------------------------------------------------
package ultrasonico_pkg;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StTrig     = 3'd1,
      StWaitRise = 3'd2,
      StMeasure  = 3'd3,
      StHoldoff  = 3'd4
   } state_t;

   // Defaults for a 50 MHz clock
   localparam int unsigned DEF_N             = 16;
   localparam int unsigned DEF_TRIG_CYCLES   = 500;      // 10 us
   localparam int unsigned DEF_DIV           = 2900;     // 1 cm of round trip
   localparam int unsigned DEF_RISE_TIMEOUT  = 250000;   // 5 ms
   localparam int unsigned DEF_ECHO_TIMEOUT  = 1900000;  // 38 ms
   localparam int unsigned DEF_PERIOD_CYCLES = 3000000;  // 60 ms

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ultrasonico_sync.sv
// -----------------------------------------------------------------------------
// ultrasonico_sync
// Two-flop synchronizer for an asynchronous sensor pin, with a third delayed
// flop for edge detection. Reusable for any slow sensor input.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset, clears all flops
//   i_async  in   asynchronous input pin
//   o_level  out  synchronized level
//   o_rise   out  one-cycle high on a synchronized 0->1 transition
//   o_fall   out  one-cycle high on a synchronized 1->0 transition
// -----------------------------------------------------------------------------
module ultrasonico_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_dly;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_dly  <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_dly  <= r_sync;
      end
   end

   assign o_level = r_sync;
   assign o_rise  = r_sync & ~r_dly;
   assign o_fall  = ~r_sync & r_dly;

endmodule

// File: rtl/ultrasonico_ctrl.sv
// -----------------------------------------------------------------------------
// ultrasonico_ctrl
// Ranging sequencer for an ultrasonic sensor: fires the trigger pulse, times
// the echo high width, converts it to distance units and reports either a
// distance (dist_valid) or a failed measurement (timeout). Trigger rising edges
// are spaced by at least PERIOD_CYCLES, in single-shot and free-running mode.
//
// Ports:
//   clk           in   system clock
//   rst_n         in   synchronous active-low reset
//   i_start       in   single-shot request, only looked at while idle
//   i_auto_en     in   free-running mode, re-trigger every period
//   i_echo        in   asynchronous echo pin from the sensor
//   o_trig        out  trigger pin to the sensor (registered)
//   o_busy        out  high whenever a measurement cycle is in progress
//   o_dist        out  last valid distance, held until the next success
//   o_dist_valid  out  one-cycle pulse when o_dist updates
//   o_timeout     out  one-cycle pulse on a failed measurement
// -----------------------------------------------------------------------------
module ultrasonico_ctrl
   import ultrasonico_pkg::*;
#(
   parameter int unsigned N             = DEF_N,
   parameter int unsigned TRIG_CYCLES   = DEF_TRIG_CYCLES,
   parameter int unsigned DIV           = DEF_DIV,
   parameter int unsigned RISE_TIMEOUT  = DEF_RISE_TIMEOUT,
   parameter int unsigned ECHO_TIMEOUT  = DEF_ECHO_TIMEOUT,
   parameter int unsigned PERIOD_CYCLES = DEF_PERIOD_CYCLES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_start,
   input  logic         i_auto_en,
   input  logic         i_echo,
   output logic         o_trig,
   output logic         o_busy,
   output logic [N-1:0] o_dist,
   output logic         o_dist_valid,
   output logic         o_timeout
);

   localparam int unsigned MAX_CYC = max_u(max_u(max_u(TRIG_CYCLES, DIV), RISE_TIMEOUT),
                                           max_u(ECHO_TIMEOUT, PERIOD_CYCLES));
   localparam int unsigned TW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [TW-1:0] TIMER_ONE   = TW'(1);
   localparam logic [TW-1:0] TRIG_LAST   = TW'(TRIG_CYCLES - 1);
   localparam logic [TW-1:0] RISE_LAST   = TW'(RISE_TIMEOUT - 1);
   localparam logic [TW-1:0] ECHO_LAST   = TW'(ECHO_TIMEOUT - 1);
   localparam logic [TW-1:0] PERIOD_LAST = TW'(PERIOD_CYCLES - 1);
   localparam logic [PW-1:0] PRESC_ONE   = PW'(1);
   localparam logic [PW-1:0] PRESC_LAST  = PW'(DIV - 1);
   localparam logic [N-1:0]  UNITS_ONE   = N'(1);
   localparam logic [N-1:0]  UNITS_MAX   = '1;

   // The cycle that detects the rise is already the first echo-high cycle, so
   // counting starts at one; with DIV == 1 that cycle is a whole unit.
   localparam logic [PW-1:0] PRESC_START = PW'((DIV == 1) ? 0 : 1);
   localparam logic [N-1:0]  UNITS_START = N'((DIV == 1) ? 1 : 0);

   logic w_echo_s;
   logic w_rise;
   logic w_fall;

   state_t        r_state;
   logic          r_trig;
   logic          r_busy;
   logic [N-1:0]  r_dist;
   logic          r_dist_valid;
   logic          r_timeout;
   logic [TW-1:0] r_timer;    // per-state timer; echo-high cycles in StMeasure
   logic [TW-1:0] r_period;   // cycles since trigger rise, saturating
   logic [PW-1:0] r_presc;
   logic [N-1:0]  r_units;

   ultrasonico_sync u_echo_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (i_echo),
      .o_level (w_echo_s),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= StIdle;
         r_trig       <= 1'b0;
         r_busy       <= 1'b0;
         r_dist       <= '0;
         r_dist_valid <= 1'b0;
         r_timeout    <= 1'b0;
         r_timer      <= '0;
         r_period     <= '0;
         r_presc      <= '0;
         r_units      <= '0;
      end else begin
         r_dist_valid <= 1'b0;
         r_timeout    <= 1'b0;

         // Saturating, so an unusually long measurement cannot wrap the spacing check
         if (r_state != StIdle && r_period != PERIOD_LAST) begin
            r_period <= r_period + TIMER_ONE;
         end

         unique case (r_state)
            StIdle: begin
               if (i_start || i_auto_en) begin
                  r_state  <= StTrig;
                  r_trig   <= 1'b1;
                  r_busy   <= 1'b1;
                  r_timer  <= '0;
                  r_period <= '0;
               end
            end

            StTrig: begin
               if (r_timer == TRIG_LAST) begin
                  r_trig  <= 1'b0;
                  r_state <= StWaitRise;
                  r_timer <= '0;
               end else begin
                  r_timer <= r_timer + TIMER_ONE;
               end
            end

            StWaitRise: begin
               // Only an edge starts a measurement; an echo already high is ignored
               if (w_rise) begin
                  r_state <= StMeasure;
                  r_timer <= TIMER_ONE;
                  r_presc <= PRESC_START;
                  r_units <= UNITS_START;
               end else if (r_timer == RISE_LAST) begin
                  r_timeout <= 1'b1;
                  r_state   <= StHoldoff;
               end else begin
                  r_timer <= r_timer + TIMER_ONE;
               end
            end

            StMeasure: begin
               // Fall is checked first so it wins over a coincident timeout
               if (w_fall) begin
                  r_dist       <= r_units;
                  r_dist_valid <= 1'b1;
                  r_state      <= StHoldoff;
               end else if (w_echo_s) begin
                  if (r_timer == ECHO_LAST) begin
                     r_timeout <= 1'b1;
                     r_state   <= StHoldoff;
                  end else begin
                     r_timer <= r_timer + TIMER_ONE;
                     if (r_presc == PRESC_LAST) begin
                        r_presc <= '0;
                        if (r_units != UNITS_MAX) begin
                           r_units <= r_units + UNITS_ONE;
                        end
                     end else begin
                        r_presc <= r_presc + PRESC_ONE;
                     end
                  end
               end
            end

            StHoldoff: begin
               if (r_period == PERIOD_LAST) begin
                  r_state <= StIdle;
                  r_busy  <= 1'b0;
               end
            end

            default: begin
               r_state <= StIdle;
               r_trig  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_trig       = r_trig;
   assign o_busy       = r_busy;
   assign o_dist       = r_dist;
   assign o_dist_valid = r_dist_valid;
   assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_ultrasonico_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ultrasonico_ctrl
// Directed bench for ultrasonico_ctrl. Instance 0 uses the small simulation
// timing set (N=8); instance 1 has N=4 and a longer echo timeout for the
// saturation case. Stimulus pushes the expected dist_valid/timeout pulses into
// a scoreboard queue; a monitor pops and compares whenever a DUT pulses.
// -----------------------------------------------------------------------------
module tb_ultrasonico_ctrl;

   typedef struct {
      int inst;
      bit is_to;
      int value;
      int cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start0, auto0, echo0, start1, auto1, echo1;
   logic       trig0, busy0, dv0, to0, trig1, busy1, dv1, to1;
   logic [7:0] dist0;
   logic [3:0] dist1;

   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   exp_dist[2];
   exp_t sb_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ultrasonico_ctrl #(
      .N(8), .TRIG_CYCLES(5), .DIV(10), .RISE_TIMEOUT(50), .ECHO_TIMEOUT(200),
      .PERIOD_CYCLES(300)
   ) u_dut0 (
      .clk(clk), .rst_n(rst_n), .i_start(start0), .i_auto_en(auto0), .i_echo(echo0),
      .o_trig(trig0), .o_busy(busy0), .o_dist(dist0), .o_dist_valid(dv0), .o_timeout(to0)
   );

   ultrasonico_ctrl #(
      .N(4), .TRIG_CYCLES(5), .DIV(10), .RISE_TIMEOUT(50), .ECHO_TIMEOUT(400),
      .PERIOD_CYCLES(300)
   ) u_dut1 (
      .clk(clk), .rst_n(rst_n), .i_start(start1), .i_auto_en(auto1), .i_echo(echo1),
      .o_trig(trig1), .o_busy(busy1), .o_dist(dist1), .o_dist_valid(dv1), .o_timeout(to1)
   );

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic trig_of(input int inst);
      return (inst == 0) ? trig0 : trig1;
   endfunction

   function automatic logic busy_of(input int inst);
      return (inst == 0) ? busy0 : busy1;
   endfunction

   task automatic set_echo(input int inst, input logic v);
      if (inst == 0) echo0 = v;
      else echo1 = v;
   endtask

   task automatic push_exp(input int inst, input bit is_to, input int value, input int at);
      exp_t e;
      e.inst = inst; e.is_to = is_to; e.value = value; e.cyc = at;
      sb_q.push_back(e);
   endtask

   // ---------------- scoreboard monitor ----------------
   task automatic chk_out(input int inst, input logic dv, input logic to, input int d);
      exp_t e;
      if (dv || to) begin
         check("dv_timeout_exclusive", int'(dv & to), 0);
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_pulse: inst %0d dv=%0b timeout=%0b dist=%0d at cycle %0d",
                     inst, dv, to, d, cyc);
         end else begin
            e = sb_q.pop_front();
            check("pulse_inst", inst, e.inst);
            check("pulse_is_timeout", int'(to), int'(e.is_to));
            check("pulse_dist", d, e.value);
            check("pulse_cycle", cyc, e.cyc);
         end
      end
   endtask

   always @(negedge clk) begin
      chk_out(0, dv0, to0, int'(dist0));
      chk_out(1, dv1, to1, int'(dist1));
   end

   // Trigger width monitor for instance 0
   logic trig0_prev = 1'b0;
   int   trig_hi = 0;
   always @(negedge clk) begin
      if (trig0) begin
         trig_hi = trig0_prev ? trig_hi + 1 : 1;
      end else if (trig0_prev) begin
         check("trig_high_cycles", trig_hi, 5);
      end
      trig0_prev = trig0;
   end

   // ---------------- stimulus helpers ----------------
   task automatic pulse_start(input int inst);
      if (inst == 0) start0 = 1'b1;
      else start1 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   // Returns the sample cycles of the next trigger rise and fall
   task automatic wait_trig(input int inst, output int rise_c, output int fall_c);
      logic prev = 1'b0;
      logic cur;
      rise_c = -1;
      fall_c = -1;
      for (int n = 0; n < 1000; n++) begin
         cur = trig_of(inst);
         if (cur && !prev) rise_c = cyc;
         if (!cur && prev) begin
            fall_c = cyc;
            return;
         end
         prev = cur;
         @(negedge clk);
      end
      n_tests++;
      n_fail++;
      $display("FAIL wait_trig: inst %0d no trigger pulse within 1000 cycles", inst);
      fall_c = cyc;
   endtask

   task automatic wait_busy_low(input int inst, output int at);
      for (int n = 0; n < 1000; n++) begin
         if (!busy_of(inst)) begin
            at = cyc;
            return;
         end
         @(negedge clk);
      end
      n_tests++;
      n_fail++;
      $display("FAIL wait_busy_low: inst %0d busy still high after 1000 cycles", inst);
      at = cyc;
   endtask

   // width > 0: echo pulse of that many cycles; 0: no echo; -1: echo stuck high.
   // Pin-to-output latency adds 2 synchronizer cycles (stuck) or 3 (fall -> dist_valid).
   task automatic measure(input int inst, input int gap, input int width, input int exp_d,
                          output int rise_c);
      int fall_c;
      wait_trig(inst, rise_c, fall_c);
      if (width == 0) begin
         push_exp(inst, 1'b1, exp_dist[inst], fall_c + 50);
         return;
      end
      repeat (gap) @(negedge clk);
      set_echo(inst, 1'b1);
      if (width < 0) begin
         push_exp(inst, 1'b1, exp_dist[inst], cyc + 202);
         return;
      end
      repeat (width) @(negedge clk);
      set_echo(inst, 1'b0);
      push_exp(inst, 1'b0, exp_d, cyc + 3);
      exp_dist[inst] = exp_d;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int rc, bc;
      int r_auto[3];
      int widths[3] = '{30, 55, 99};
      int dists[3]  = '{3, 5, 9};

      rst_n = 1'b0;
      start0 = 1'b0; auto0 = 1'b0; echo0 = 1'b0;
      start1 = 1'b0; auto1 = 1'b0; echo1 = 1'b0;
      exp_dist[0] = 0;
      exp_dist[1] = 0;
      repeat (3) @(negedge clk);
      check("reset_trig", int'(trig0), 0);
      check("reset_busy", int'(busy0), 0);
      check("reset_dist", int'(dist0), 0);
      check("reset_dist_valid", int'(dv0), 0);
      check("reset_timeout", int'(to0), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Nominal shot: 73 echo cycles -> 7 units; busy for 300 cycles from trig rise
      pulse_start(0);
      measure(0, 20, 73, 7, rc);
      wait_busy_low(0, bc);
      check("busy_duration", bc - rc, 300);
      repeat (5) @(negedge clk);

      // No echo: timeout 50 cycles after trig fall, dist keeps 7
      pulse_start(0);
      measure(0, 20, 0, 0, rc);
      wait_busy_low(0, bc);
      check("busy_duration_noecho", bc - rc, 300);
      repeat (5) @(negedge clk);

      // Stuck echo: timeout after 200 high cycles; start during holdoff is dropped
      pulse_start(0);
      measure(0, 20, -1, 0, rc);
      repeat (240) @(negedge clk);
      check("busy_in_holdoff", int'(busy0), 1);
      pulse_start(0);
      echo0 = 1'b0;
      wait_busy_low(0, bc);
      check("busy_duration_stuck", bc - rc, 300);
      repeat (20) @(negedge clk);
      check("start_ignored_trig", int'(trig0), 0);
      check("start_ignored_busy", int'(busy0), 0);

      // Free-running: three shots, then auto_en drops mid-measurement
      auto0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         measure(0, 20, widths[i], dists[i], r_auto[i]);
      end
      auto0 = 1'b0;
      check("auto_spacing_1", r_auto[1] - r_auto[0], 301);
      check("auto_spacing_2", r_auto[2] - r_auto[1], 301);
      wait_busy_low(0, bc);
      repeat (20) @(negedge clk);
      check("auto_off_rests_trig", int'(trig0), 0);
      check("auto_off_rests_busy", int'(busy0), 0);

      // Reset while measuring: outputs clear, no pulses, then a clean shot
      pulse_start(0);
      wait_trig(0, rc, bc);
      repeat (20) @(negedge clk);
      echo0 = 1'b1;
      repeat (30) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midreset_trig", int'(trig0), 0);
      check("midreset_busy", int'(busy0), 0);
      check("midreset_dist", int'(dist0), 0);
      rst_n = 1'b1;
      echo0 = 1'b0;
      exp_dist[0] = 0;
      repeat (20) @(negedge clk);
      pulse_start(0);
      measure(0, 20, 73, 7, rc);
      wait_busy_low(0, bc);
      check("busy_duration_after_reset", bc - rc, 300);

      // Saturation on the 4-bit instance: 250 cycles -> 25 units, clamps to 15
      pulse_start(1);
      measure(1, 20, 250, 15, rc);
      wait_busy_low(1, bc);
      check("sat_busy_duration", bc - rc, 300);

      repeat (10) @(negedge clk);
      check("scoreboard_drained", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
